// File: rtl/toeplitz_word_serializer.sv
// Word FIFO that captures extracted words on qstrobe and streams them LSB-chunk first over valid/ready.
// Optional: define DROP_COUNT_EN to add the saturating 16-bit dropped-word counter on drop_cnt.
module toeplitz_word_serializer #(
    parameter int L     = 128,
    parameter int OW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [L-1:0]                 q,
    input  logic                         qstrobe,
    output logic [OW-1:0]                m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [15:0]                  drop_cnt
);

    localparam int NCH = L / OW;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = $clog2(DEPTH + 1);

    logic [L-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] chunk_idx;
    logic [LW-1:0] level_q;
    logic          overflow_q;

    logic          full;
    logic          empty;
    logic          xfer;
    logic          last_chunk;
    logic          pop;
    logic          push;
    logic          drop;
    logic [L-1:0]  head;

    assign full       = (level_q == LW'(DEPTH));
    assign empty      = (level_q == '0);
    assign xfer       = m_valid & m_ready;
    assign last_chunk = (chunk_idx == CW'(NCH - 1));
    assign pop        = xfer & last_chunk;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push       = qstrobe & (~full | pop);
    assign drop       = qstrobe & full & ~pop;
    assign head       = mem[rd_ptr];

    assign m_valid  = ~empty;
    assign level    = level_q;
    assign overflow = overflow_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        m_data = '0;
        if (!empty) begin
            m_data = head[int'(chunk_idx) * OW +: OW];
        end
    end

    // NOTE: storage is deliberately not reset; level/pointers decide what is valid, and this keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            chunk_idx  <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (xfer) begin
                chunk_idx <= last_chunk ? '0 : chunk_idx + CW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef DROP_COUNT_EN
    logic [15:0] drop_cnt_q;

    // Saturates instead of wrapping so a long-running loss is never under-reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_toeplitz_word_serializer.sv
// Directed bench for toeplitz_word_serializer (L=128, OW=8, DEPTH=4); word n carries byte n*16+k in chunk k.
module tb_toeplitz_word_serializer;

    logic         clk;
    logic         reset;
    logic [127:0] q;
    logic         qstrobe;
    logic [7:0]   m_data;
    logic         m_valid;
    logic         m_ready;
    logic [2:0]   level;
    logic         overflow;
    logic [15:0]  drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef DROP_COUNT_EN
    localparam int EXP_DROP = 1;
`else
    localparam int EXP_DROP = 0;
`endif

    toeplitz_word_serializer #(.L(128), .OW(8), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .q        (q),
        .qstrobe  (qstrobe),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] make_word(input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            w[k*8 +: 8] = 8'(n * 16 + k);
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects m_ready=1 and word n at the head with chunk 0 pending.
    task automatic stream_word(input int n, input string tag);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_w%0d_c%0d", tag, n, k), {127'd0, m_valid}, 128'd1);
            check($sformatf("%s_w%0d_d%0d", tag, n, k), {120'd0, m_data}, 128'(n * 16 + k));
            step();
        end
    endtask

    initial begin
        int exp_idx;
        logic rdy;

        reset   = 1'b1;
        q       = '0;
        qstrobe = 1'b0;
        m_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", {127'd0, m_valid}, 128'd0);
        check("rst_data", {120'd0, m_data}, 128'd0);
        check("rst_level", {125'd0, level}, 128'd0);
        check("rst_ovf", {127'd0, overflow}, 128'd0);
        check("rst_drop", {112'd0, drop_cnt}, 128'd0);

        // 1: single word, m_ready held high
        m_ready = 1'b1;
        q       = 128'h0F0E0D0C0B0A09080706050403020100;
        qstrobe = 1'b1;
        step();
        qstrobe = 1'b0;
        check("t1_level_first", {125'd0, level}, 128'd1);
        stream_word(0, "t1");
        check("t1_valid_after", {127'd0, m_valid}, 128'd0);
        check("t1_level_after", {125'd0, level}, 128'd0);
        check("t1_data_after", {120'd0, m_data}, 128'd0);

        // 2: backpressure, m_ready pattern 1,0,0 repeating
        q       = make_word(0);
        qstrobe = 1'b1;
        step();
        qstrobe = 1'b0;
        exp_idx = 0;
        for (int cyc = 0; cyc < 60 && exp_idx < 16; cyc++) begin
            rdy     = (cyc % 3 == 0);
            m_ready = rdy;
            check($sformatf("t2_valid_%0d", cyc), {127'd0, m_valid}, 128'd1);
            check($sformatf("t2_data_%0d", cyc), {120'd0, m_data}, 128'(exp_idx));
            step();
            if (rdy) exp_idx++;
        end
        check("t2_complete", 128'(exp_idx), 128'd16);
        check("t2_valid_after", {127'd0, m_valid}, 128'd0);

        // 3: overflow with five strobes into a stalled 4-deep FIFO
        m_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            q       = make_word(n);
            qstrobe = 1'b1;
            step();
        end
        qstrobe = 1'b0;
        check("t3_level", {125'd0, level}, 128'd4);
        check("t3_ovf", {127'd0, overflow}, 128'd1);
        check("t3_drop", {112'd0, drop_cnt}, 128'(EXP_DROP));
        check("t3_head", {120'd0, m_data}, 128'h00);
        m_ready = 1'b1;
        for (int n = 0; n < 4; n++) stream_word(n, "t3");
        check("t3_valid_after", {127'd0, m_valid}, 128'd0);
        check("t3_ovf_sticky", {127'd0, overflow}, 128'd1);

        // 4: full FIFO, push coincides with the last chunk of the head
        reset = 1'b1;
        step();
        reset   = 1'b0;
        m_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            q       = make_word(n);
            qstrobe = 1'b1;
            step();
        end
        qstrobe = 1'b0;
        check("t4_level_full", {125'd0, level}, 128'd4);
        check("t4_ovf_clear", {127'd0, overflow}, 128'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("t4_w0_d%0d", k), {120'd0, m_data}, 128'(k));
            if (k == 15) begin
                q       = make_word(5);
                qstrobe = 1'b1;
            end
            step();
        end
        qstrobe = 1'b0;
        check("t4_level_kept", {125'd0, level}, 128'd4);
        check("t4_ovf_kept", {127'd0, overflow}, 128'd0);
        check("t4_drop_kept", {112'd0, drop_cnt}, 128'd0);
        stream_word(1, "t4");
        stream_word(2, "t4");
        stream_word(3, "t4");
        stream_word(5, "t4");
        check("t4_valid_after", {127'd0, m_valid}, 128'd0);

        // 5: reset mid-word with a second word queued
        m_ready = 1'b0;
        q       = make_word(0);
        qstrobe = 1'b1;
        step();
        q = make_word(1);
        step();
        qstrobe = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_pre_d%0d", k), {120'd0, m_data}, 128'(k));
            step();
        end
        check("t5_pre_level", {125'd0, level}, 128'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_valid", {127'd0, m_valid}, 128'd0);
        check("t5_level", {125'd0, level}, 128'd0);
        check("t5_ovf", {127'd0, overflow}, 128'd0);
        check("t5_data", {120'd0, m_data}, 128'd0);
        step();
        check("t5_idle1", {127'd0, m_valid}, 128'd0);
        step();
        check("t5_idle2", {127'd0, m_valid}, 128'd0);
        q       = make_word(2);
        qstrobe = 1'b1;
        step();
        qstrobe = 1'b0;
        stream_word(2, "t5");
        check("t5_valid_after", {127'd0, m_valid}, 128'd0);

        // 6: back-to-back strobes, contiguous 32 chunks
        m_ready = 1'b1;
        q       = make_word(3);
        qstrobe = 1'b1;
        step();
        q = make_word(4);
        check("t6_first_d0", {120'd0, m_data}, 128'h30);
        step();
        qstrobe = 1'b0;
        check("t6_level", {125'd0, level}, 128'd2);
        for (int k = 1; k < 16; k++) begin
            check($sformatf("t6_w3_c%0d", k), {127'd0, m_valid}, 128'd1);
            check($sformatf("t6_w3_d%0d", k), {120'd0, m_data}, 128'(48 + k));
            step();
        end
        stream_word(4, "t6");
        check("t6_valid_after", {127'd0, m_valid}, 128'd0);
        check("t6_level_after", {125'd0, level}, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
